// File: rtl/mbist_pkg.sv
// Shared types and March element tables for the MBIST engine.
// Each element is one pass over the address space with a short op list.
package mbist_pkg;

    typedef enum logic [1:0] {OP_W0, OP_W1, OP_R0, OP_R1} op_e;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;

    typedef struct packed {
        logic       down;   // 1 = descending address order
        logic [1:0] nops;   // ops per address (1 or 2)
        op_e        op0;
        op_e        op1;
    } elem_t;

    localparam int         MAX_ELEM         = 8;
    localparam logic [2:0] NUM_ELEM_MARCH_C = 3'd6;
    localparam logic [2:0] NUM_ELEM_MATS    = 3'd3;

    // Trailing entries are padding so any 3-bit element index stays in range.
    localparam elem_t MARCH_C_TBL [MAX_ELEM] = '{
        '{1'b0, 2'd1, OP_W0, OP_W0},
        '{1'b0, 2'd2, OP_R0, OP_W1},
        '{1'b0, 2'd2, OP_R1, OP_W0},
        '{1'b1, 2'd2, OP_R0, OP_W1},
        '{1'b1, 2'd2, OP_R1, OP_W0},
        '{1'b0, 2'd1, OP_R0, OP_R0},
        '{1'b0, 2'd1, OP_R0, OP_R0},
        '{1'b0, 2'd1, OP_R0, OP_R0}
    };

    localparam elem_t MATS_TBL [MAX_ELEM] = '{
        '{1'b0, 2'd1, OP_W0, OP_W0},
        '{1'b0, 2'd2, OP_R0, OP_W1},
        '{1'b1, 2'd2, OP_R1, OP_W0},
        '{1'b0, 2'd1, OP_R0, OP_R0},
        '{1'b0, 2'd1, OP_R0, OP_R0},
        '{1'b0, 2'd1, OP_R0, OP_R0},
        '{1'b0, 2'd1, OP_R0, OP_R0},
        '{1'b0, 2'd1, OP_R0, OP_R0}
    };

    function automatic elem_t get_elem(input logic mode, input logic [2:0] idx);
        return mode ? MATS_TBL[idx] : MARCH_C_TBL[idx];
    endfunction

    function automatic logic is_read(input op_e op);
        return (op == OP_R0) || (op == OP_R1);
    endfunction

endpackage

// File: rtl/mbist_fault_log.sv
// Spare-row fault log: dedupes faulty addresses into a small CAM and
// answers remap queries; overflow is flagged by saturating the count.
module mbist_fault_log #(
    parameter int  ADDR_W     = 5,
    parameter int  NUM_SPARES = 2,
    localparam int CNT_W      = $clog2(NUM_SPARES + 2),
    localparam int IDX_W      = (NUM_SPARES > 1) ? $clog2(NUM_SPARES) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              log_en,
    input  logic [ADDR_W-1:0] log_addr,
    output logic [CNT_W-1:0]  fault_cnt,
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic              remap_hit,
    output logic [IDX_W-1:0]  remap_idx
);

    logic [NUM_SPARES-1:0] valid_q;
    logic [ADDR_W-1:0]     addr_q [NUM_SPARES];
    logic                  log_hit;
    logic                  have_free;
    logic [IDX_W-1:0]      free_idx;

    // Descending scans so the lowest matching / free index wins.
    always_comb begin
        log_hit   = 1'b0;
        have_free = 1'b0;
        free_idx  = '0;
        remap_hit = 1'b0;
        remap_idx = '0;
        for (int i = NUM_SPARES - 1; i >= 0; i--) begin
            if (valid_q[i] && addr_q[i] == log_addr) begin
                log_hit = 1'b1;
            end
            if (!valid_q[i]) begin
                have_free = 1'b1;
                free_idx  = IDX_W'(i);
            end
            if (valid_q[i] && addr_q[i] == lookup_addr) begin
                remap_hit = 1'b1;
                remap_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            valid_q   <= '0;
            fault_cnt <= '0;
            for (int i = 0; i < NUM_SPARES; i++) begin
                addr_q[i] <= '0;
            end
        end else if (log_en && !log_hit) begin
            if (have_free) begin
                valid_q[free_idx] <= 1'b1;
                addr_q[free_idx]  <= log_addr;
                fault_cnt         <= fault_cnt + CNT_W'(1);
            end else begin
                fault_cnt <= CNT_W'(NUM_SPARES + 1);
            end
        end
    end

endmodule

// File: rtl/mbist_march_engine.sv
// MBIST sequencer: walks March C- or MATS+ over a synchronous-read SRAM,
// compares read data and feeds mismatching addresses to the fault log.
module mbist_march_engine
    import mbist_pkg::*;
#(
    parameter int  ADDR_W     = 5,
    parameter int  DATA_W     = 8,
    parameter int  NUM_SPARES = 2,
    localparam int CNT_W      = $clog2(NUM_SPARES + 2),
    localparam int IDX_W      = (NUM_SPARES > 1) ? $clog2(NUM_SPARES) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode,
    output logic              mem_we,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic              repairable,
    output logic [CNT_W-1:0]  fault_cnt,
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic              remap_hit,
    output logic [IDX_W-1:0]  remap_idx,
    output logic [1:0]        dbg_state
);

    state_e            state_q;
    logic              mode_q;
    logic [2:0]        elem_q;
    logic              op_idx_q;
    logic              cmp_q;     // second cycle of a read: data on mem_rdata
    logic [ADDR_W-1:0] addr_q;

    elem_t             cur_e, inc_e, nxt_e;
    op_e               cur_op, nxt_op_e;
    logic [2:0]        nxt_elem;
    logic              nxt_op;
    logic              nxt_cmp;
    logic [ADDR_W-1:0] nxt_addr;
    logic              finish;
    logic              last_op, last_addr, last_elem;
    logic [DATA_W-1:0] exp_data;
    logic              log_en;
    logic              accept;

    assign cur_e     = get_elem(mode_q, elem_q);
    assign inc_e     = get_elem(mode_q, elem_q + 3'd1);
    assign cur_op    = op_idx_q ? cur_e.op1 : cur_e.op0;
    assign last_op   = ({1'b0, op_idx_q} + 2'd1) == cur_e.nops;
    assign last_addr = cur_e.down ? (addr_q == '0) : (addr_q == '1);
    assign last_elem = elem_q == ((mode_q ? NUM_ELEM_MATS : NUM_ELEM_MARCH_C) - 3'd1);

    // Position of the next cycle within the element / address / op walk.
    always_comb begin
        nxt_elem = elem_q;
        nxt_op   = op_idx_q;
        nxt_addr = addr_q;
        nxt_cmp  = 1'b0;
        finish   = 1'b0;
        if (is_read(cur_op) && !cmp_q) begin
            nxt_cmp = 1'b1;
        end else if (!last_op) begin
            nxt_op = 1'b1;
        end else begin
            nxt_op = 1'b0;
            if (!last_addr) begin
                nxt_addr = cur_e.down ? addr_q - ADDR_W'(1) : addr_q + ADDR_W'(1);
            end else if (last_elem) begin
                finish = 1'b1;
            end else begin
                nxt_elem = elem_q + 3'd1;
                nxt_addr = {ADDR_W{inc_e.down}};
            end
        end
    end

    assign nxt_e    = get_elem(mode_q, nxt_elem);
    assign nxt_op_e = nxt_op ? nxt_e.op1 : nxt_e.op0;

    assign exp_data = (cur_op == OP_R1) ? '1 : '0;
    assign log_en   = (state_q == ST_RUN) && cmp_q && (mem_rdata != exp_data);
    assign accept   = start && (state_q != ST_RUN);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            mode_q    <= 1'b0;
            elem_q    <= '0;
            op_idx_q  <= 1'b0;
            cmp_q     <= 1'b0;
            addr_q    <= '0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        // Both algorithms open with an ascending w0 pass.
                        state_q   <= ST_RUN;
                        mode_q    <= mode;
                        elem_q    <= '0;
                        op_idx_q  <= 1'b0;
                        cmp_q     <= 1'b0;
                        addr_q    <= '0;
                        mem_we    <= 1'b1;
                        mem_re    <= 1'b0;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (finish) begin
                        state_q   <= ST_DONE;
                        mem_we    <= 1'b0;
                        mem_re    <= 1'b0;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end else begin
                        elem_q    <= nxt_elem;
                        op_idx_q  <= nxt_op;
                        cmp_q     <= nxt_cmp;
                        addr_q    <= nxt_addr;
                        mem_we    <= !is_read(nxt_op_e);
                        mem_re    <= is_read(nxt_op_e) && !nxt_cmp;
                        mem_addr  <= nxt_addr;
                        mem_wdata <= (nxt_op_e == OP_W1) ? '1 : '0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    mbist_fault_log #(
        .ADDR_W     (ADDR_W),
        .NUM_SPARES (NUM_SPARES)
    ) u_fault_log (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (accept),
        .log_en      (log_en),
        .log_addr    (addr_q),
        .fault_cnt   (fault_cnt),
        .lookup_addr (lookup_addr),
        .remap_hit   (remap_hit),
        .remap_idx   (remap_idx)
    );

    assign fail       = done && (fault_cnt != '0);
    assign repairable = done && (fault_cnt <= CNT_W'(NUM_SPARES));
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_mbist_march_engine.sv
// Bench for mbist_march_engine: 32x8 memory model with injectable stuck-at
// faults, strobe scoreboard from a March model, and table-driven result checks.
module tb_mbist_march_engine;
    import mbist_pkg::*;

    localparam int W0 = 0, W1 = 1, R0 = 2, R1 = 3;
    localparam int BUDGET = 2000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       mode = 1'b0;
    logic       mem_we, mem_re;
    logic [4:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata = 8'h00;
    logic       busy, done, fail, repairable;
    logic [1:0] fault_cnt;
    logic [4:0] lookup_addr = 5'd0;
    logic       remap_hit;
    logic       remap_idx;
    logic [1:0] dbg_state;

    mbist_march_engine #(.ADDR_W(5), .DATA_W(8), .NUM_SPARES(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .mode        (mode),
        .mem_we      (mem_we),
        .mem_re      (mem_re),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .busy        (busy),
        .done        (done),
        .fail        (fail),
        .repairable  (repairable),
        .fault_cnt   (fault_cnt),
        .lookup_addr (lookup_addr),
        .remap_hit   (remap_hit),
        .remap_idx   (remap_idx),
        .dbg_state   (dbg_state)
    );

    // clock/reset
    always #5 clk = ~clk;

    // memory model: sa0 forces bit 3 low, sa1 forces bit 0 high on read
    logic [7:0]  mem [32];
    logic [31:0] sa0_map = '0;
    logic [31:0] sa1_map = '0;

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= (mem[mem_addr] & ~(sa0_map[mem_addr] ? 8'h08 : 8'h00))
                                 | (sa1_map[mem_addr] ? 8'h01 : 8'h00);
    end

    // scoreboard
    int total = 0;
    int bad = 0;
    int cur_id = -1;
    logic [14:0] exp_q[$];
    logic        mon_en = 1'b0;
    int          conflicts = 0;
    logic [14:0] mon_exp, mon_act;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL vec%0d %s: got %0h expected %0h", cur_id, name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (mem_we && mem_re) conflicts++;
            if (mem_we || mem_re) begin
                total++;
                mon_act = {mem_we, mem_re, mem_addr, mem_we ? mem_wdata : 8'h00};
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL vec%0d strobe: got %0h expected none", cur_id, mon_act);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (mon_act !== mon_exp) begin
                        bad++;
                        $display("FAIL vec%0d strobe: got %0h expected %0h", cur_id, mon_act, mon_exp);
                    end
                end
            end
        end
    end

    // March algorithm model: direction, op count, op list per element
    int mc_dn [6] = '{0, 0, 0, 1, 1, 0};
    int mc_n  [6] = '{1, 2, 2, 2, 2, 1};
    int mc_o0 [6] = '{W0, R0, R1, R0, R1, R0};
    int mc_o1 [6] = '{0, W1, W0, W1, W0, 0};
    int mt_dn [3] = '{0, 0, 1};
    int mt_n  [3] = '{1, 2, 2};
    int mt_o0 [3] = '{W0, R0, R1};
    int mt_o1 [3] = '{0, W1, W0};

    task automatic build_exp(input logic m);
        int ne, dn, n, op, a;
        logic [14:0] ent;
        ne = m ? 3 : 6;
        for (int e = 0; e < ne; e++) begin
            dn = m ? mt_dn[e] : mc_dn[e];
            n  = m ? mt_n[e] : mc_n[e];
            for (int i = 0; i < 32; i++) begin
                a = (dn != 0) ? 31 - i : i;
                for (int k = 0; k < n; k++) begin
                    if (k == 0) op = m ? mt_o0[e] : mc_o0[e];
                    else        op = m ? mt_o1[e] : mc_o1[e];
                    if (op == W0 || op == W1)
                        ent = {1'b1, 1'b0, 5'(a), (op == W1) ? 8'hFF : 8'h00};
                    else
                        ent = {1'b0, 1'b1, 5'(a), 8'h00};
                    exp_q.push_back(ent);
                end
            end
        end
    endtask

    // vector table: mode, poke, sa0_map, sa1_map, cycles, fail, cnt, rep,
    // lookup addrs {a2,a1,a0}, expected hits {h2,h1,h0}, expected idx {i2,i1,i0}
    typedef struct {
        logic        mode;
        logic        poke;
        logic [31:0] sa0_map;
        logic [31:0] sa1_map;
        int          exp_cycles;
        logic        exp_fail;
        logic [1:0]  exp_cnt;
        logic        exp_rep;
        logic [14:0] lk_addr;
        logic [2:0]  lk_hit;
        logic [2:0]  lk_idx;
    } vec_t;

    vec_t vecs [7];

    task automatic run_vec(input vec_t v);
        int cyc;
        sa0_map = v.sa0_map;
        sa1_map = v.sa1_map;
        exp_q.delete();
        build_exp(v.mode);
        conflicts = 0;
        mon_en = 1'b1;
        @(negedge clk);
        start = 1'b1;
        mode  = v.mode;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        check("busy_after_start", 32'(busy), 32'd1);
        check("done_cleared", 32'(done), 32'd0);
        while (!done && cyc < BUDGET) begin
            if (v.poke && (cyc == 50 || cyc == 200)) begin
                start = 1'b1;
                mode  = ~v.mode;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        mon_en = 1'b0;
        check("done_cycles", 32'(cyc), 32'(v.exp_cycles));
        check("strobes_left", 32'(exp_q.size()), 32'd0);
        check("we_re_conflict", 32'(conflicts), 32'd0);
        check("busy_end", 32'(busy), 32'd0);
        check("fail", 32'(fail), 32'(v.exp_fail));
        check("fault_cnt", 32'(fault_cnt), 32'(v.exp_cnt));
        check("repairable", 32'(repairable), 32'(v.exp_rep));
        check("idle_addr_data", {19'd0, mem_addr, mem_wdata}, 32'd0);
        check("state_done", 32'(dbg_state), 32'(ST_DONE));
        for (int k = 0; k < 3; k++) begin
            lookup_addr = v.lk_addr[k*5 +: 5];
            #1;
            check("remap_hit", 32'(remap_hit), 32'(v.lk_hit[k]));
            check("remap_idx", 32'(remap_idx), v.lk_hit[k] ? 32'(v.lk_idx[k]) : 32'd0);
        end
    endtask

    initial begin
        int cyc;
        vecs[0] = '{1'b0, 1'b0, 32'h0, 32'h0, 481, 1'b0, 2'd0, 1'b1,
                    {5'd0, 5'd0, 5'd7}, 3'b000, 3'b000};
        vecs[1] = '{1'b1, 1'b0, 32'h0, 32'h0, 225, 1'b0, 2'd0, 1'b1,
                    {5'd0, 5'd0, 5'd7}, 3'b000, 3'b000};
        vecs[2] = '{1'b0, 1'b0, 32'h80, 32'h0, 481, 1'b1, 2'd1, 1'b1,
                    {5'd8, 5'd8, 5'd7}, 3'b001, 3'b000};
        vecs[3] = '{1'b0, 1'b0, 32'h0, 32'h0010_0210, 481, 1'b1, 2'd3, 1'b0,
                    {5'd20, 5'd9, 5'd4}, 3'b011, 3'b010};
        vecs[4] = '{1'b0, 1'b0, 32'h0, 32'h0, 481, 1'b0, 2'd0, 1'b1,
                    {5'd20, 5'd9, 5'd4}, 3'b000, 3'b000};
        vecs[5] = '{1'b1, 1'b0, 32'h80, 32'h0, 225, 1'b1, 2'd1, 1'b1,
                    {5'd8, 5'd8, 5'd7}, 3'b001, 3'b000};
        vecs[6] = '{1'b0, 1'b1, 32'h0, 32'h0, 481, 1'b0, 2'd0, 1'b1,
                    {5'd0, 5'd0, 5'd7}, 3'b000, 3'b000};

        for (int i = 0; i < 32; i++) mem[i] = 8'h00;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_fail", 32'(fail), 32'd0);
        check("rst_repairable", 32'(repairable), 32'd0);
        check("rst_fault_cnt", 32'(fault_cnt), 32'd0);
        check("rst_strobes", {30'd0, mem_we, mem_re}, 32'd0);
        check("rst_addr_data", {19'd0, mem_addr, mem_wdata}, 32'd0);
        check("rst_remap", {30'd0, remap_hit, remap_idx}, 32'd0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));

        for (int i = 0; i < 7; i++) begin
            cur_id = i;
            run_vec(vecs[i]);
        end

        // reset mid-test at cycle 100, then a clean rerun
        cur_id = 100;
        sa0_map = 32'h80;
        sa1_map = '0;
        @(negedge clk);
        start = 1'b1;
        mode  = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        while (cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("busy_before_abort", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("abort_strobes", {30'd0, mem_we, mem_re}, 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_addr", 32'(mem_addr), 32'd0);
        check("abort_state", 32'(dbg_state), 32'(ST_IDLE));
        @(posedge clk); #1;
        check("abort_strobes_2", {30'd0, mem_we, mem_re}, 32'd0);
        rst_n = 1'b1;
        cur_id = 101;
        run_vec(vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mbist_march_engine.md
Name: mbist_march_engine

Overview:
Parametrised MBIST/MBISR controller. Runs a selectable March algorithm (March C- or MATS+) over a synchronous-read SRAM of configurable depth and width. Captures unique faulty addresses into a spare-row repair table and exposes a remap lookup. Sits between the top-level start/status pins and the memory under test.

Parameters:
ADDR_W, 5, memory address width; depth N = 2^ADDR_W
DATA_W, 8, memory word width; backgrounds are all-0 / all-1 words
NUM_SPARES, 2, number of spare rows (fault-log entries), 1..8

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
start  in  1  single-cycle pulse; begins a test when idle
mode  in  1  sampled on accepted start: 0 = March C-, 1 = MATS+
mem_we  out  1  memory write strobe
mem_re  out  1  memory read strobe; mem_rdata valid the following cycle
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  write data
mem_rdata  in  DATA_W  read data, 1-cycle latency
busy  out  1  test in progress
done  out  1  sticky completion flag
fail  out  1  fault_cnt != 0, valid when done
repairable  out  1  fault_cnt <= NUM_SPARES, valid when done
fault_cnt  out  clog2(NUM_SPARES+2)  unique faulty addresses, saturates at NUM_SPARES+1
lookup_addr  in  ADDR_W  logical address for remap query
remap_hit  out  1  lookup_addr matches a valid log entry (combinational)
remap_idx  out  clog2(NUM_SPARES)  spare index of the match; 0 when no hit

Behaviour:
- Clock clk; reset rst_n synchronous, active-low. Reset: all outputs 0; log entries invalid; FSM in IDLE. Reset mid-test aborts immediately, with no further memory strobes.
- FSM: IDLE -> RUN -> DONE. DONE behaves as IDLE for start. start is ignored while busy.
- Accepted start clears done, fault_cnt and the log, latches mode, sets busy, and enters element 0 at the next cycle.
- March C-: E0 ⇕(w0); E1 ⇑(r0,w1); E2 ⇑(r1,w0); E3 ⇓(r0,w1); E4 ⇓(r1,w0); E5 ⇕(r0). ⇕ runs ascending.
- MATS+: E0 ⇕(w0); E1 ⇑(r0,w1); E2 ⇓(r1,w0).
- Op timing:
  - Write: 1 cycle, mem_we=1.
  - Read: 2 cycles. Issue cycle has mem_re=1. Compare cycle has no strobe and mem_addr held. Compare is mem_rdata vs. the expected background.
  - Ops within an address run back-to-back. Address steps on the last op of the element, then the next element starts at 0 (⇑) or N-1 (⇓).
- Cycle count from the first strobe to the last op: March C- = 15N, MATS+ = 7N.
  - The cycle after the last op: busy=0, done=1, and fail/repairable are valid.
  - ADDR_W=5 gives 480 / 224 cycles.
- Never assert mem_we and mem_re together. Outside RUN, mem_addr and mem_wdata are 0.
- Fault logging, on a compare mismatch:
  - If the address is already in the log, do nothing. Dedupe applies across elements.
  - Else if the log has a free slot, store the address in the lowest free index and increment fault_cnt.
  - Else (log full), fault_cnt goes to NUM_SPARES+1 and saturates there. Each unique address is counted at most once while the log has room; overflow is only flagged.
- done, fail, repairable and the log hold until the next accepted start or reset.
- Remap lookup is active at all times. Mid-test it reflects the partial log.
  - When several entries match (impossible by dedupe), report the lowest index.

Decomposition:
- mbist_pkg holds:
  - the op enum (OP_W0, OP_W1, OP_R0, OP_R1)
  - the FSM state enum
  - the March C- and MATS+ element tables (direction, op count, op list) as constant arrays indexed by element
  - the NUM_ELEM constants
- Sub-module mbist_fault_log (params ADDR_W, NUM_SPARES):
  - ports: clear, log_en and log_addr in; fault_cnt out; lookup port
  - owns the CAM-style dedupe/compare logic
- The engine keeps the sequencer and the memory interface.

Test Plan:
- Fault-free 32x8 memory, mode=0, start pulse: done rises exactly 481 cycles after start; fail=0; repairable=1; fault_cnt=0.
- Fault-free, mode=1: done after 225 cycles; fail=0. Writes observed only on E0/E1/E2 with correct data. Address order is 0..31 on E1 and 31..0 on E2.
- Stuck-at-0 on bit 3 of address 7, mode=0:
  - done; fail=1; fault_cnt=1; repairable=1.
  - lookup_addr=7 gives remap_hit=1, remap_idx=0.
  - lookup_addr=8 gives remap_hit=0.
- Stuck-at-1 at addresses 4, 9, 20 with NUM_SPARES=2: fault_cnt=3 (saturated); repairable=0; entries hold 4 and 9 in idx 0 and 1; address 20 gives no hit.
- start pulses while busy are ignored (timing unchanged). rst_n=0 at cycle 100 of a test: the next cycle has all strobes 0 and busy=0. A new start then completes normally with fault_cnt=0.
- Second start after a failing run with the fault removed: log cleared at start; final fail=0; remap_hit=0 for the old address.
